// File: rtl/sd_fifo_sched.sv
// ---------------------------------------------------------------------------
// sd_fifo_sched
//
// Shares the single SD-side port of the four-channel SD FIFO block among
// four SD-side requesters, using round-robin arbitration with bounded bursts.
//   ch0 : reader, drains FIFO 1 (WB -> SD)
//   ch1 : writer, fills  FIFO 2 (SD -> WB), data = wr_dat[7:0]
//   ch2 : reader, drains FIFO 3 (WB -> SD)
//   ch3 : writer, fills  FIFO 4 (SD -> WB), data = wr_dat[15:8]
//
// Ports
//   sd_clk      clock, rising edge
//   rst         asynchronous active-high reset
//   ch_en[3:0]  per-channel enable
//   req[3:0]    per-channel level request
//   wr_dat      {ch3 byte, ch1 byte} write data
//   ack[3:0]    one-hot strobe, a transfer happens this cycle
//   rd_dat      read data returned to reader channels (sd_dat_i passthrough)
//   rd_vld[3:0] one-hot, rd_dat valid for ch0 or ch2 (cycle after read ack)
//   fifo_full   FIFO full flags, bit n-1 = FIFO n (bit 0 = FIFO 1)
//   fifo_empty  FIFO empty flags, bit n-1 = FIFO n (bit 0 = FIFO 1)
//   sd_adr_o    FIFO port address (granted channel while busy, else 0)
//   sd_dat_o    FIFO write data
//   sd_we_o     FIFO write strobe
//   sd_re_o     FIFO read strobe
//   sd_dat_i    FIFO read data (registered RAM output)
//   busy        a channel currently holds the grant
//   cur_ch      granted channel (0 when not busy)
// ---------------------------------------------------------------------------
module sd_fifo_sched #(
    parameter int BURST_LEN = 4,
    parameter int CNT_W     = 4
) (
    input  logic        sd_clk,
    input  logic        rst,
    input  logic [3:0]  ch_en,
    input  logic [3:0]  req,
    input  logic [15:0] wr_dat,
    output logic [3:0]  ack,
    output logic [7:0]  rd_dat,
    output logic [3:0]  rd_vld,
    input  logic [3:0]  fifo_full,
    input  logic [3:0]  fifo_empty,
    output logic [1:0]  sd_adr_o,
    output logic [7:0]  sd_dat_o,
    output logic        sd_we_o,
    output logic        sd_re_o,
    input  logic [7:0]  sd_dat_i,
    output logic        busy,
    output logic [1:0]  cur_ch
);

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BURST_LEN - 1);

    state_t           state_reg, state_next;
    logic [1:0]       gnt_reg, gnt_next;
    logic [1:0]       ptr_reg, ptr_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [3:0]       rd_vld_reg;

    logic [3:0]       elig;
    logic             xfer;
    logic [3:0]       ack_c;
    logic             we_c;
    logic             re_c;
    logic [7:0]       dat_c;

    // Readers are blocked by an empty source FIFO, writers by a full
    // destination FIFO; channel n maps to FIFO n+1, i.e. flag bit n.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_elig
            if (gi % 2 == 0) begin : g_rd
                assign elig[gi] = ch_en[gi] & req[gi] & ~fifo_empty[gi];
            end else begin : g_wr
                assign elig[gi] = ch_en[gi] & req[gi] & ~fifo_full[gi];
            end
        end
    endgenerate

    // Readers never look at full, writers never look at empty.
    logic unused_flags;
    assign unused_flags = ^{fifo_full[0], fifo_full[2], fifo_empty[1], fifo_empty[3]};

    // First eligible channel scanning start, start+1, ... (mod 4).
    // Iterating downward lets the nearest candidate overwrite farther ones.
    function automatic logic [1:0] pick(input logic [3:0] e, input logic [1:0] start);
        logic [1:0] r;
        logic [1:0] idx;
        r = start;
        for (int k = 3; k >= 0; k--) begin
            idx = start + 2'(k);
            if (e[idx]) r = idx;
        end
        return r;
    endfunction

    assign xfer = (state_reg == BURST) && elig[gnt_reg];

    always_comb begin
        state_next = state_reg;
        gnt_next   = gnt_reg;
        ptr_next   = ptr_reg;
        cnt_next   = cnt_reg;
        ack_c      = 4'b0000;
        we_c       = 1'b0;
        re_c       = 1'b0;
        dat_c      = 8'h00;

        case (state_reg)
            IDLE: begin
                if (|elig) begin
                    state_next = BURST;
                    gnt_next   = pick(elig, ptr_reg);
                    cnt_next   = '0;
                end
            end

            BURST: begin
                if (xfer) begin
                    ack_c = 4'b0001 << gnt_reg;
                    if (gnt_reg[0]) begin
                        we_c  = 1'b1;
                        dat_c = gnt_reg[1] ? wr_dat[15:8] : wr_dat[7:0];
                    end else begin
                        re_c = 1'b1;
                    end
                end

                if (xfer && (cnt_reg != CNT_LAST)) begin
                    cnt_next = cnt_reg + 1'b1;
                end else begin
                    // Burst exhausted or grantee lost eligibility: rotate the
                    // pointer past it and re-arbitrate without a bubble.
                    ptr_next = gnt_reg + 2'd1;
                    cnt_next = '0;
                    if (|elig) begin
                        gnt_next = pick(elig, gnt_reg + 2'd1);
                    end else begin
                        state_next = IDLE;
                    end
                end
            end

            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge sd_clk or posedge rst) begin
        if (rst) begin
            state_reg  <= IDLE;
            gnt_reg    <= 2'd0;
            ptr_reg    <= 2'd0;
            cnt_reg    <= '0;
            rd_vld_reg <= 4'b0000;
        end else begin
            state_reg  <= state_next;
            gnt_reg    <= gnt_next;
            ptr_reg    <= ptr_next;
            cnt_reg    <= cnt_next;
            // The FIFO RAM output is registered, so read data for an ack
            // in this cycle shows up on sd_dat_i in the next one.
            rd_vld_reg <= ack_c & 4'b0101;
        end
    end

    assign busy     = (state_reg == BURST);
    assign cur_ch   = busy ? gnt_reg : 2'd0;
    assign sd_adr_o = busy ? gnt_reg : 2'd0;
    assign ack      = ack_c;
    assign sd_we_o  = we_c;
    assign sd_re_o  = re_c;
    assign sd_dat_o = dat_c;
    assign rd_vld   = rd_vld_reg;
    assign rd_dat   = sd_dat_i;

endmodule

// File: tb/tb_sd_fifo_sched.sv
// ---------------------------------------------------------------------------
// tb_sd_fifo_sched
//
// Drives sd_fifo_sched with directed and randomized request/flag patterns and
// compares every output each cycle with a transaction-level reference model
// of the round-robin burst scheduler (grant owner, transfers done in the
// current grant, round-robin start point).
// ---------------------------------------------------------------------------
module tb_sd_fifo_sched;

    localparam int BL = 4;

    logic        sd_clk = 1'b0;
    logic        rst;
    logic [3:0]  ch_en;
    logic [3:0]  req;
    logic [15:0] wr_dat;
    logic [3:0]  ack;
    logic [7:0]  rd_dat;
    logic [3:0]  rd_vld;
    logic [3:0]  fifo_full;
    logic [3:0]  fifo_empty;
    logic [1:0]  sd_adr_o;
    logic [7:0]  sd_dat_o;
    logic        sd_we_o;
    logic        sd_re_o;
    logic [7:0]  sd_dat_i;
    logic        busy;
    logic [1:0]  cur_ch;

    int n_vec  = 0;
    int n_err  = 0;
    int n_cyc  = 0;

    // Reference model state
    bit         m_busy;
    int         m_g;
    int         m_done;
    int         m_ptr;
    logic [3:0] m_rdv;
    int         ch0_acks;

    always #5 sd_clk = ~sd_clk;

    sd_fifo_sched #(.BURST_LEN(BL), .CNT_W(4)) dut (
        .sd_clk     (sd_clk),
        .rst        (rst),
        .ch_en      (ch_en),
        .req        (req),
        .wr_dat     (wr_dat),
        .ack        (ack),
        .rd_dat     (rd_dat),
        .rd_vld     (rd_vld),
        .fifo_full  (fifo_full),
        .fifo_empty (fifo_empty),
        .sd_adr_o   (sd_adr_o),
        .sd_dat_o   (sd_dat_o),
        .sd_we_o    (sd_we_o),
        .sd_re_o    (sd_re_o),
        .sd_dat_i   (sd_dat_i),
        .busy       (busy),
        .cur_ch     (cur_ch)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s cycle=%0d got=%0h expected=%0h", tag, n_cyc, obs, exp);
        end
    endtask

    function automatic int pick(input logic [3:0] e, input int start);
        for (int k = 0; k < 4; k++) begin
            if (e[(start + k) % 4]) return (start + k) % 4;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_busy = 1'b0;
        m_g    = 0;
        m_done = 0;
        m_ptr  = 0;
        m_rdv  = 4'b0000;
    endtask

    // One clock cycle: called at posedge+1, drives inputs, checks at the
    // falling edge, advances the model, returns at the next posedge+1.
    task automatic step(input logic [3:0] en, input logic [3:0] rq,
                        input logic [3:0] fe, input logic [3:0] ff);
        logic [3:0] e;
        bit         x;
        logic [3:0] exp_ack;
        logic [7:0] exp_dat;
        logic [3:0] nrdv;
        int         p;

        ch_en      = en;
        req        = rq;
        fifo_empty = fe;
        fifo_full  = ff;
        wr_dat     = 16'($urandom);
        sd_dat_i   = 8'($urandom);
        #4;

        for (int c = 0; c < 4; c++) begin
            e[c] = en[c] & rq[c] & ((c % 2 == 0) ? ~fe[c] : ~ff[c]);
        end
        x       = m_busy && e[m_g];
        exp_ack = x ? 4'(1 << m_g) : 4'b0000;
        exp_dat = (x && (m_g % 2 == 1)) ? ((m_g == 1) ? wr_dat[7:0] : wr_dat[15:8]) : 8'h00;

        $display("cyc %0d en=%b req=%b fe=%b ff=%b -> ack=%b adr=%0d we=%b re=%b rd_vld=%b busy=%b cur=%0d",
                 n_cyc, en, rq, fe, ff, ack, sd_adr_o, sd_we_o, sd_re_o, rd_vld, busy, cur_ch);

        check("ack",    32'(ack),      32'(exp_ack));
        check("we",     32'(sd_we_o),  32'(x && (m_g % 2 == 1)));
        check("re",     32'(sd_re_o),  32'(x && (m_g % 2 == 0)));
        check("adr",    32'(sd_adr_o), m_busy ? 32'(m_g) : 32'd0);
        check("wdat",   32'(sd_dat_o), 32'(exp_dat));
        check("busy",   32'(busy),     32'(m_busy));
        check("cur_ch", 32'(cur_ch),   m_busy ? 32'(m_g) : 32'd0);
        check("rd_vld", 32'(rd_vld),   32'(m_rdv));
        check("rd_dat", 32'(rd_dat),   32'(sd_dat_i));

        if (x && m_g == 0) ch0_acks++;

        nrdv = (x && (m_g % 2 == 0)) ? 4'(1 << m_g) : 4'b0000;
        if (!m_busy) begin
            p = pick(e, m_ptr);
            if (p >= 0) begin
                m_busy = 1'b1;
                m_g    = p;
                m_done = 0;
            end
        end else if (x && (m_done + 1 < BL)) begin
            m_done++;
        end else begin
            m_ptr = (m_g + 1) % 4;
            p     = pick(e, m_ptr);
            if (p >= 0) begin
                m_g    = p;
                m_done = 0;
            end else begin
                m_busy = 1'b0;
            end
        end
        m_rdv = nrdv;

        @(posedge sd_clk);
        #1;
        n_cyc++;
    endtask

    function automatic logic [3:0] rbits(input int pct);
        logic [3:0] v;
        for (int i = 0; i < 4; i++) v[i] = ($urandom_range(0, 99) < pct);
        return v;
    endfunction

    initial begin
        rst        = 1'b1;
        ch_en      = 4'b0000;
        req        = 4'b0000;
        wr_dat     = 16'h0000;
        fifo_full  = 4'b0000;
        fifo_empty = 4'b1111;
        sd_dat_i   = 8'h00;
        ch0_acks   = 0;
        model_reset();

        repeat (2) @(posedge sd_clk);
        #1;
        check("rst_ack",  32'(ack),      32'd0);
        check("rst_busy", 32'(busy),     32'd0);
        check("rst_vld",  32'(rd_vld),   32'd0);
        check("rst_adr",  32'(sd_adr_o), 32'd0);
        check("rst_we",   32'(sd_we_o),  32'd0);
        check("rst_re",   32'(sd_re_o),  32'd0);
        check("rst_dat",  32'(sd_dat_o), 32'd0);
        check("rst_cur",  32'(cur_ch),   32'd0);
        rst = 1'b0;

        // All four channels continuously eligible: 0,1,2,3,0 rotation.
        for (int i = 0; i < 40; i++) step(4'b1111, 4'b1111, 4'b0000, 4'b0000);

        // Single reader with data, then its FIFO runs empty.
        for (int i = 0; i < 12; i++) step(4'b1111, 4'b0001, 4'b0000, 4'b0000);
        for (int i = 0; i < 3; i++)  step(4'b1111, 4'b0001, 4'b0001, 4'b0000);

        // Writer ch1 blocked by full, ch3 takes over; then ch1 resumes.
        for (int i = 0; i < 6; i++) step(4'b1111, 4'b1010, 4'b0000, 4'b0000);
        for (int i = 0; i < 6; i++) step(4'b1111, 4'b1010, 4'b0000, 4'b0010);
        for (int i = 0; i < 6; i++) step(4'b1111, 4'b1010, 4'b0000, 4'b0000);

        // ch2 disabled while requesting.
        for (int i = 0; i < 3; i++)  step(4'b1111, 4'b1100, 4'b0000, 4'b0000);
        for (int i = 0; i < 12; i++) step(4'b1011, 4'b1100, 4'b0000, 4'b0000);

        // Randomized: dense requests, then sparse requests with busy flags.
        for (int i = 0; i < 800; i++)
            step(rbits(90), rbits(80), rbits(15), rbits(15));
        for (int i = 0; i < 800; i++)
            step(rbits(70), rbits(35), rbits(40), rbits(40));

        // Reset mid-burst: ch0 alone, abort after two acks.
        for (int i = 0; i < 6; i++) step(4'b1111, 4'b0000, 4'b0000, 4'b0000);
        ch0_acks = 0;
        begin : wait_two
            int budget;
            budget = 0;
            while (ch0_acks < 2 && budget < 50) begin
                step(4'b1111, 4'b0001, 4'b0000, 4'b0000);
                budget++;
            end
            check("ch0_two_acks", 32'(ch0_acks), 32'd2);
        end
        // Inputs still keep ch0 eligible; assert reset mid-cycle.
        rst = 1'b1;
        #1;
        check("async_ack",  32'(ack),     32'd0);
        check("async_re",   32'(sd_re_o), 32'd0);
        check("async_vld",  32'(rd_vld),  32'd0);
        check("async_busy", 32'(busy),    32'd0);
        model_reset();
        @(posedge sd_clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 10; i++) step(4'b1111, 4'b0001, 4'b0000, 4'b0000);

        // Request drop after one transfer, ch1 follows.
        for (int i = 0; i < 2; i++) step(4'b1111, 4'b0011, 4'b0000, 4'b0000);
        for (int i = 0; i < 8; i++) step(4'b1111, 4'b1010, 4'b0000, 4'b0000);
        for (int i = 0; i < 12; i++) step(4'b1111, 4'b1011, 4'b0000, 4'b0000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/sd_fifo_sched.md
Name: sd_fifo_sched

Overview:
SD-clock-domain scheduler that shares the single SD-side port of the four-channel SD FIFO block among four SD-side requesters. Channels 0 and 2 are readers draining FIFO 1 and FIFO 3 (WB to SD). Channels 1 and 3 are writers filling FIFO 2 and FIFO 4 (SD to WB). Arbitration is round-robin with bounded bursts, gated per channel by FIFO flags and a per-channel enable. The block drives the FIFO's sd_adr_i/sd_we_i/sd_re_i/sd_dat_i and returns read data to the requesting channel.

Parameters:
BURST_LEN, 4, max consecutive transfers per grant (1..16)
CNT_W, 4, burst counter width; must satisfy 2^CNT_W >= BURST_LEN

Ports:
sd_clk  in  1  clock; all logic rising-edge
rst  in  1  reset, asynchronous, active-high
ch_en  in  4  per-channel enable (configuration, static or changed at any time)
req  in  4  per-channel transfer request, level; bit n = channel n
wr_dat  in  16  {ch3 byte, ch1 byte} write data for writer channels
ack  out  4  one-hot transfer strobe; transfer happened this cycle
rd_dat  out  8  read data for reader channels
rd_vld  out  4  one-hot; rd_dat valid for channel 0 or 2
fifo_full  in  4  [1:4] from FIFO block
fifo_empty  in  4  [1:4] from FIFO block
sd_adr_o  out  2  to FIFO sd_adr_i
sd_dat_o  out  8  to FIFO sd_dat_i
sd_we_o  out  1  to FIFO sd_we_i
sd_re_o  out  1  to FIFO sd_re_i
sd_dat_i  in  8  from FIFO sd_dat_o (registered RAM output)
busy  out  1  state is BURST
cur_ch  out  2  currently granted channel (valid when busy)

Behaviour:
- Reset (async): state IDLE, gnt=0, ptr=0, cnt=0, rd_vld=0. Combinational outputs evaluate to ack=0, sd_we_o=0, sd_re_o=0, sd_adr_o=0, sd_dat_o=0, busy=0, cur_ch=0. Reset mid-burst aborts immediately and drops the in-flight rd_vld.
- Eligibility, per cycle:
  - elig[0] = ch_en[0] & req[0] & !fifo_empty[1]
  - elig[1] = ch_en[1] & req[1] & !fifo_full[2]
  - elig[2] = ch_en[2] & req[2] & !fifo_empty[3]
  - elig[3] = ch_en[3] & req[3] & !fifo_full[4]
- Pick(start): the first eligible channel in order start, start+1, ... mod 4.
- IDLE state:
  - No transfer.
  - If any elig: go to BURST with gnt=pick(ptr), cnt=0.
- BURST state, granted channel g eligible (transfer cycle):
  - ack[g]=1; sd_adr_o=g.
  - g odd: sd_we_o=1, sd_dat_o=wr_dat byte of g. g even: sd_re_o=1.
  - cnt+1 < BURST_LEN: stay, cnt+=1.
  - cnt+1 == BURST_LEN: ptr=g+1 and re-arbitrate with no bubble. Next state is BURST with gnt=pick(g+1), which may be g again if g is the only eligible channel; cnt=0. IDLE if nothing is eligible.
- BURST state, g not eligible (request dropped, flag set, or ch_en cleared):
  - No transfer; all strobes 0; sd_adr_o=g.
  - ptr=g+1; re-arbitrate exactly as above.
- sd_adr_o: holds gnt whenever busy, otherwise 0. sd_we_o and sd_re_o are never both high and are high only on transfer cycles.
- Read return:
  - Registered: rd_vld[g] = 1 in the cycle after a read ack.
  - rd_dat = sd_dat_i, passed through combinationally.
  - Back-to-back reads give back-to-back rd_vld.
- Latency: req rising in cycle N from IDLE gives ack in cycle N+1 at the earliest; read data arrives in N+2.
- Flags are trusted as sampled each cycle. A transfer in cycle N that makes the FIFO full/empty is followed by a flag update; until that flag appears, further transfers are still gated by the FIFO block's internal cke qualification.
- Simultaneous requests resolve purely via ptr; there is no fixed priority.

Test Plan:
- Reset mid-burst: ch0 eligible, 2 acks issued, assert rst -> ack, sd_re_o and rd_vld drop asynchronously. After release: ch0 eligible in cycle 0 -> IDLE in cycle 0, first ack in cycle 1.
- Single reader, BURST_LEN=4, FIFO1 holds 10 bytes 0xA0..0xA9:
  - acks in cycles 1-4 and 5-8 (same channel, no bubble), then 9-10.
  - rd_vld[0] one cycle after each ack, rd_dat=0xA0..0xA9 in order.
  - fifo_empty[1] rises -> no ack, state IDLE.
- All four channels requesting continuously, all FIFOs non-full/non-empty -> grants 0,1,2,3,0 each for exactly 4 transfers. sd_we_o only on channels 1/3, sd_re_o only on 0/2, sd_adr_o equals cur_ch.
- Writer ch1 into FIFO2 with 510 free locations -> exactly 510 acks, then fifo_full[2] blocks. Grant passes to eligible ch3 the next cycle. ch1 resumes after WB reads free space.
- Clear ch_en[2] during ch2's 2nd transfer -> that cycle has no ack, grant moves to ch3. ch2 is never granted while ch_en[2]=0 even with req[2]=1.
- req drop: ch0 drops req after 1 transfer -> re-arbitration cycle with no strobe, then ch1 granted. ptr order is preserved (ch0 is next served after ch3).
